// File: rtl/tx_shift_ctrl.sv
// Packet transmit controller: pops bytes from a FWFT FIFO and shifts them out MSB first.
// Optional `define TX_ABORT_EN adds an abort input that returns the FSM to IDLE.
module tx_shift_ctrl #(
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_rdata,
  input  logic       byte_sent,
  input  logic       data_sent,
`ifdef TX_ABORT_EN
  input  logic       abort,
`endif
  output logic       fifo_read,
  output logic       transmitting,
  output logic       serial_out,
  output logic       tx_done,
  output logic [5:0] byte_count
);

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, STALL, DONE} state_t;

  state_t     state, state_nxt;
  logic [7:0] shift_reg;
  logic [2:0] bit_cnt;
  logic       abort_i;

`ifdef TX_ABORT_EN
  assign abort_i = abort;
`else
  assign abort_i = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = fifo_empty ? STALL : LOAD;
      LOAD:  state_nxt = SHIFT;
      SHIFT: if (byte_sent) begin
               if (data_sent)        state_nxt = DONE;
               else if (!fifo_empty) state_nxt = LOAD;
               else                  state_nxt = STALL;
             end
      STALL: if (!fifo_empty) state_nxt = LOAD;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort_i) state_nxt = IDLE;
  end

  // Seven shifts bring the LSB to bit 7, where it holds until the timer ends the byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_reg  <= 8'h00;
      bit_cnt    <= 3'd0;
      byte_count <= 6'd0;
    end else if (!abort_i) begin
      if (state == IDLE && start) byte_count <= 6'd0;
      if (state == LOAD) begin
        shift_reg <= fifo_rdata;
        bit_cnt   <= 3'd0;
        if (byte_count != 6'd63) byte_count <= byte_count + 6'd1;
      end else if (state == SHIFT && bit_cnt != 3'd7) begin
        shift_reg <= {shift_reg[6:0], 1'b0};
        bit_cnt   <= bit_cnt + 3'd1;
      end
    end
  end

  assign fifo_read    = (state == LOAD);
  assign transmitting = (state == SHIFT);
  assign tx_done      = (state == DONE);
  assign serial_out   = (state == SHIFT) ? shift_reg[7] : IDLE_LEVEL;

endmodule

// File: tb/tb_tx_shift_ctrl.sv
// Bench for tx_shift_ctrl: FIFO/timer model with queues, random data, directed packet scenarios.
module tb_tx_shift_ctrl;
  logic       clk = 1'b0;
  logic       rst, start, fifo_empty, byte_sent, data_sent;
  logic [7:0] fifo_rdata;
  logic       fifo_read, transmitting, serial_out, tx_done;
  logic [5:0] byte_count;

  always #5 clk = ~clk;

  tx_shift_ctrl #(.IDLE_LEVEL(1'b1)) dut (
    .clk(clk), .rst(rst), .start(start), .fifo_empty(fifo_empty),
    .fifo_rdata(fifo_rdata), .byte_sent(byte_sent), .data_sent(data_sent),
    .fifo_read(fifo_read), .transmitting(transmitting), .serial_out(serial_out),
    .tx_done(tx_done), .byte_count(byte_count)
  );

  int checks = 0, failures = 0;
  logic [7:0] q[$], refill[$], exp_bytes[$], sent[$];
  int gaps[$];
  int pkt_len, popped, reads, dones, tcnt, blen, low_run, refill_after;
  bit trans_now, start_req;
  logic [7:0] cur_byte, shbyte;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    q.push_back(b);
    exp_bytes.push_back(b);
  endtask

  // Drive inputs for the coming edge, advance one cycle, then observe.
  task automatic tick();
    int idx;
    fifo_empty = (q.size() == 0);
    fifo_rdata = (q.size() != 0) ? q[0] : 8'h00;
    byte_sent  = trans_now && (tcnt == blen);
    data_sent  = byte_sent ? (popped + 0 == pkt_len) : ($urandom_range(0, 3) == 0);
    start      = start_req | (trans_now && ($urandom_range(0, 4) == 0));
    if (fifo_read === 1'b1) begin
      chk("read_nonempty", fifo_empty, 0);
      if (q.size() != 0) cur_byte = q.pop_front();
      popped++; reads++;
      blen = $urandom_range(8, 11);
    end
    @(negedge clk);
    trans_now = (transmitting === 1'b1);
    if (trans_now) begin
      tcnt++;
      if (tcnt == 1 && popped > 1) gaps.push_back(low_run);
      low_run = 0;
      idx = (tcnt <= 8) ? 8 - tcnt : 0;
      chk("serial_bit", serial_out, cur_byte[idx]);
      if (tcnt <= 8) shbyte = {shbyte[6:0], serial_out};
      if (tcnt == 8) sent.push_back(shbyte);
    end else begin
      tcnt = 0;
      low_run++;
      chk("serial_idle", serial_out, 1);
      if (refill.size() != 0 && q.size() == 0 && low_run == refill_after)
        while (refill.size() != 0) push(refill.pop_front());
    end
    if (tx_done === 1'b1) dones++;
  endtask

  task automatic begin_pkt(input int n);
    pkt_len = n; popped = 0; reads = 0; dones = 0; low_run = 0;
    gaps.delete(); sent.delete();
    start_req = 1'b1;
    tick();
    start_req = 1'b0;
  endtask

  task automatic finish_pkt(input int budget);
    int k = 0;
    while (dones == 0 && k < budget) begin tick(); k++; end
    chk("pkt_finish", dones, 1);
    repeat (3) tick();
    chk("done_once", dones, 1);
    chk("reads", reads, pkt_len);
    chk("byte_count", byte_count, (pkt_len > 63) ? 63 : pkt_len);
    chk("sent_count", sent.size(), pkt_len);
    foreach (sent[i]) if (i < exp_bytes.size()) chk("byte_data", sent[i], exp_bytes[i]);
    exp_bytes.delete();
  endtask

  initial begin
    int k, n, cut;
    rst = 1'b1; start = 1'b0; fifo_empty = 1'b1; fifo_rdata = 8'h00;
    byte_sent = 1'b0; data_sent = 1'b0; start_req = 1'b0;
    trans_now = 1'b0; tcnt = 0; blen = 8; low_run = 0; refill_after = 0;
    pkt_len = 0; popped = 0; cur_byte = 8'h00; shbyte = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_fifo_read", fifo_read, 0);
    chk("rst_transmitting", transmitting, 0);
    chk("rst_tx_done", tx_done, 0);
    chk("rst_serial", serial_out, 1);
    chk("rst_byte_count", byte_count, 0);
    rst = 1'b0;
    repeat (2) tick();

    // single 0xA5 byte
    push(8'hA5);
    begin_pkt(1);
    finish_pkt(100);

    // five back-to-back bytes: one low cycle between bytes
    for (int i = 0; i < 5; i++) push(8'($urandom));
    begin_pkt(5);
    finish_pkt(200);
    chk("gap_count", gaps.size(), 4);
    foreach (gaps[i]) chk("gap_len", gaps[i], 1);

    // FIFO runs dry after byte 2, refilled after 10 stall cycles
    push(8'($urandom)); push(8'($urandom));
    refill.push_back(8'($urandom)); refill.push_back(8'($urandom));
    refill_after = 10;
    begin_pkt(4);
    finish_pkt(200);
    chk("stall_gap_count", gaps.size(), 3);
    if (gaps.size() == 3) begin
      chk("stall_gap0", gaps[0], 1);
      chk("stall_gap1", gaps[1], 11);
      chk("stall_gap2", gaps[2], 1);
    end
    refill_after = 0;

    // start with empty FIFO waits in STALL
    begin_pkt(2);
    repeat (6) tick();
    chk("empty_no_read", reads, 0);
    chk("empty_not_tx", transmitting, 0);
    push(8'($urandom)); push(8'($urandom));
    finish_pkt(150);

    // reset in the middle of byte 2
    for (int i = 0; i < 3; i++) push(8'($urandom));
    begin_pkt(3);
    k = 0;
    while (!(popped == 2 && tcnt == 3) && k < 200) begin tick(); k++; end
    chk("reach_byte2", popped, 2);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_read", fifo_read, 0);
    chk("mid_rst_tx", transmitting, 0);
    chk("mid_rst_done", tx_done, 0);
    chk("mid_rst_serial", serial_out, 1);
    chk("mid_rst_count", byte_count, 0);
    trans_now = 1'b0; tcnt = 0;
    repeat (2) tick();
    rst = 1'b0;
    repeat (30) tick();
    chk("post_rst_reads", reads, 2);
    chk("post_rst_done", dones, 0);
    chk("post_rst_count", byte_count, 0);
    q.delete(); exp_bytes.delete();

    // byte_count saturation
    for (int i = 0; i < 64; i++) push(8'($urandom));
    begin_pkt(64);
    finish_pkt(64 * 15 + 50);

    // random packets, some with a mid-packet stall
    for (int p = 0; p < 4; p++) begin
      n = $urandom_range(1, 6);
      cut = (n >= 2 && $urandom_range(0, 1) == 1) ? $urandom_range(1, n - 1) : n;
      for (int i = 0; i < n; i++) begin
        if (i < cut) push(8'($urandom));
        else refill.push_back(8'($urandom));
      end
      refill_after = $urandom_range(1, 12);
      begin_pkt(n);
      finish_pkt(300);
      refill.delete();
      refill_after = 0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
